// File: rtl/idu0_iq_pkg.sv
// Shared types and the instruction decode table for the decode-stage-0
// instruction queue (idu0_iq) and its combinational decoder (idu0_dec).
package idu0_iq_pkg;

  localparam int INSTR_LEN = 32;
  localparam int XLEN      = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic legal;
    logic alu;
    logic imm20;
    logic jal;
    logic jalr;
    logic imm12;
    logic condbr;
    logic load;
    logic store;
  } decode_out_t;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      instr_tag;
  } iq_entry_t;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      instr_tag;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic [4:0]           shamt;
    logic [31:0]          imm;
    logic                 imm_valid;
    decode_out_t          dec;
  } idu0_out_t;

  // Class bits are only raised for encodings we recognise; anything else
  // comes out all-zero with legal=0 and is forwarded without a trap.
  function automatic decode_out_t decode_table(input logic [INSTR_LEN-1:0] i);
    decode_out_t d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    d  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      OPC_LUI, OPC_AUIPC: d.imm20 = 1'b1;
      OPC_JAL: begin
        d.imm20 = 1'b1;
        d.jal   = 1'b1;
      end
      OPC_JALR: begin
        d.jalr  = (f3 == 3'b000);
        d.imm12 = (f3 == 3'b000);
      end
      OPC_BRANCH: d.condbr = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   d.load   = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OPC_STORE:  d.store  = f3 inside {3'b000, 3'b001, 3'b010};
      OPC_OPIMM: begin
        if (f3 == 3'b001)      d.alu = (f7 == 7'b0000000);
        else if (f3 == 3'b101) d.alu = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   d.alu = 1'b1;
        d.imm12 = d.alu;
      end
      OPC_OP: d.alu = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default: d = '0;
    endcase
    d.legal = d.imm20 | d.jalr | d.condbr | d.load | d.store | d.alu;
    return d;
  endfunction

endpackage

// File: rtl/idu0_dec.sv
// Combinational decode of one queue entry into the registered-output format:
// register fields, class-selected sign-extended immediate, imm_valid.
module idu0_dec
  import idu0_iq_pkg::*;
(
  input  iq_entry_t entry,
  output idu0_out_t dec_out
);

  decode_out_t d;
  logic [31:0] i;
  logic [31:0] imm;

  assign i = entry.instr;
  assign d = decode_table(entry.instr);

  // U-type only when it is not a jump, so jal picks up the J immediate.
  always_comb begin
    imm = '0;
    if (d.imm20 & ~d.jal)      imm = {i[31:12], 12'h000};
    else if (d.jal)            imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    else if (d.imm12 | d.load) imm = {{20{i[31]}}, i[31:20]};
    else if (d.condbr)         imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    else if (d.store)          imm = {{20{i[31]}}, i[31:25], i[11:7]};
  end

  always_comb begin
    dec_out           = '0;
    dec_out.instr     = entry.instr;
    dec_out.instr_tag = entry.instr_tag;
    dec_out.rs1_addr  = i[19:15];
    dec_out.rs2_addr  = i[24:20];
    dec_out.rd_addr   = i[11:7];
    dec_out.shamt     = i[24:20];
    dec_out.imm       = imm;
    dec_out.imm_valid = (d.imm20 & ~d.jal) | d.imm12 | d.condbr | d.load | d.store;
    dec_out.dec       = d;
  end

endmodule

// File: rtl/idu0_iq.sv
// Decode stage 0: DEPTH-entry instruction FIFO with valid/ready back-pressure
// and a registered decode of the head entry. Optional counters: IDU0_IQ_PERF_EN.
module idu0_iq
  import idu0_iq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic                 instr_valid,
  input  logic [XLEN-1:0]      instr_tag,
  output logic                 instr_ready,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  output idu0_out_t            idu0_out,
  output logic                 idu0_out_valid,
  output logic [CNT_W-1:0]     iq_count,
  output logic                 iq_full,
  output logic                 iq_empty
`ifdef IDU0_IQ_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_stall_cyc,
  output logic [PERF_W-1:0]    perf_full_cyc,
  output logic [PERF_W-1:0]    perf_illegal
`endif
);

  localparam int AW = CNT_W - 1;

  iq_entry_t        mem [DEPTH];
  iq_entry_t        head_entry;
  idu0_out_t        head_dec;
  logic [CNT_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  assign iq_count    = count_q;
  assign iq_full     = (count_q == CNT_W'(DEPTH));
  assign iq_empty    = (count_q == '0);
  assign instr_ready = ~iq_full & ~rst;
  assign push        = instr_valid & instr_ready & ~pipe_flush;
  assign pop         = ~iq_empty & ~pipe_stall & ~pipe_flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= '{instr: instr, instr_tag: instr_tag};
    end
  end

  // Pointers carry an extra wrap bit; the low bits index the storage.
  always_ff @(posedge clk) begin
    if (rst || pipe_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr_q[AW-1:0]];

  idu0_dec u_dec (
    .entry   (head_entry),
    .dec_out (head_dec)
  );

  // An empty queue drops valid but keeps the last payload on the bus.
  always_ff @(posedge clk) begin
    if (rst || pipe_flush) begin
      idu0_out       <= '0;
      idu0_out_valid <= 1'b0;
    end else if (!pipe_stall) begin
      idu0_out_valid <= ~iq_empty;
      if (!iq_empty) idu0_out <= head_dec;
    end
  end

`ifdef IDU0_IQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_full_cyc  <= '0;
      perf_illegal   <= '0;
    end else begin
      if (pipe_stall && idu0_out_valid && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + PERF_W'(1);
      if (iq_full && instr_valid && (perf_full_cyc != '1))
        perf_full_cyc <= perf_full_cyc + PERF_W'(1);
      if (pop && !head_dec.dec.legal && (perf_illegal != '1))
        perf_illegal <= perf_illegal + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_idu0_iq.sv
// Self-checking bench for idu0_iq: queue-based reference model compared every
// cycle, plus directed literal checks; perf counters checked with IDU0_IQ_PERF_EN.
module tb_idu0_iq;
  import idu0_iq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int PERF_W = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [INSTR_LEN-1:0] instr;
  logic                 instr_valid;
  logic [XLEN-1:0]      instr_tag;
  logic                 instr_ready;
  logic                 pipe_stall;
  logic                 pipe_flush;
  idu0_out_t            idu0_out;
  logic                 idu0_out_valid;
  logic [CNT_W-1:0]     iq_count;
  logic                 iq_full;
  logic                 iq_empty;
`ifdef IDU0_IQ_PERF_EN
  logic [PERF_W-1:0]    perf_stall_cyc;
  logic [PERF_W-1:0]    perf_full_cyc;
  logic [PERF_W-1:0]    perf_illegal;
`endif

  idu0_iq #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_tag      (instr_tag),
    .instr_ready    (instr_ready),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .idu0_out       (idu0_out),
    .idu0_out_valid (idu0_out_valid),
    .iq_count       (iq_count),
    .iq_full        (iq_full),
    .iq_empty       (iq_empty)
`ifdef IDU0_IQ_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_full_cyc  (perf_full_cyc),
    .perf_illegal   (perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, written per opcode from the instruction-set rules.
  function automatic idu0_out_t model_decode(input logic [31:0] ins, input logic [31:0] tag);
    idu0_out_t   o;
    decode_out_t d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ival;
    logic [12:0] bimm;
    logic [20:0] jimm;
    logic [11:0] simm;
    o    = '0;
    d    = '0;
    f3   = ins[14:12];
    f7   = ins[31:25];
    ival = '0;
    bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    simm = {ins[31:25], ins[11:7]};
    case (ins[6:0])
      7'h37, 7'h17: begin d.imm20 = 1; ival = ins & 32'hFFFF_F000; end
      7'h6F: begin d.imm20 = 1; d.jal = 1; ival = 32'($signed(jimm)); end
      7'h67: if (f3 == 0) begin d.jalr = 1; d.imm12 = 1; ival = 32'($signed(ins[31:20])); end
      7'h63: if (f3 != 2 && f3 != 3) begin d.condbr = 1; ival = 32'($signed(bimm)); end
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
               d.load = 1; ival = 32'($signed(ins[31:20]));
             end
      7'h23: if (f3 <= 2) begin d.store = 1; ival = 32'($signed(simm)); end
      7'h13: if ((f3 != 1 && f3 != 5) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20))) begin
               d.alu = 1; d.imm12 = 1; ival = 32'($signed(ins[31:20]));
             end
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) d.alu = 1;
      default: ;
    endcase
    d.legal       = d.imm20 | d.jalr | d.condbr | d.load | d.store | d.alu;
    o.instr       = ins;
    o.instr_tag   = tag;
    o.rs1_addr    = ins[19:15];
    o.rs2_addr    = ins[24:20];
    o.rd_addr     = ins[11:7];
    o.shamt       = ins[24:20];
    o.imm         = ival;
    o.imm_valid   = (d.imm20 & ~d.jal) | d.imm12 | d.condbr | d.load | d.store;
    o.dec         = d;
    return o;
  endfunction

  iq_entry_t mq[$];
  idu0_out_t m_out = '0;
  bit        m_valid = 0;
  longint    m_stall = 0, m_full = 0, m_illegal = 0;

  // Model advance on every rising edge from the inputs presented before it.
  always @(posedge clk) begin
    if (rst) begin
      m_stall = 0; m_full = 0; m_illegal = 0;
    end else begin
      if (pipe_stall && m_valid) m_stall++;
      if (mq.size() == DEPTH && instr_valid) m_full++;
      if (!pipe_flush && !pipe_stall && mq.size() > 0 && !model_decode(mq[0].instr, mq[0].instr_tag).dec.legal)
        m_illegal++;
    end
    if (rst || pipe_flush) begin
      mq.delete();
      m_out   = '0;
      m_valid = 0;
    end else begin
      bit can_push;
      can_push = instr_valid && (mq.size() < DEPTH);
      if (!pipe_stall) begin
        m_valid = (mq.size() > 0);
        if (mq.size() > 0) begin
          m_out = model_decode(mq[0].instr, mq[0].instr_tag);
          void'(mq.pop_front());
        end
      end
      if (can_push) mq.push_back('{instr: instr, instr_tag: instr_tag});
    end
  end

  always @(negedge clk) begin
    checkOutput("out_valid", idu0_out_valid, m_valid);
    checkOutput("out_payload", idu0_out, m_out);
    checkOutput("iq_count", iq_count, mq.size());
    checkOutput("iq_full", iq_full, mq.size() == DEPTH);
    checkOutput("iq_empty", iq_empty, mq.size() == 0);
    checkOutput("instr_ready", instr_ready, !rst && mq.size() < DEPTH);
`ifdef IDU0_IQ_PERF_EN
    checkOutput("perf_stall_cyc", perf_stall_cyc, m_stall);
    checkOutput("perf_full_cyc", perf_full_cyc, m_full);
    checkOutput("perf_illegal", perf_illegal, m_illegal);
`endif
  end

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] ins,
                               input logic [31:0] tag, input bit st, input bit fl);
    rst         = r;
    instr_valid = v;
    instr       = ins;
    instr_tag   = tag;
    pipe_stall  = st;
    pipe_flush  = fl;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 4) == 0) return r;
    return {r[31:7], opcs[$urandom_range(0, 8)]};
  endfunction

`ifdef IDU0_IQ_PERF_EN
  logic [PERF_W-1:0] base;
`endif

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, '0, 0, 0);
    checkOutput("reset_empty", iq_empty, 1'b1);
    checkOutput("reset_valid", idu0_out_valid, 1'b0);

    // addi x1,x0,5: visible two cycles after presentation
    applyStimulus(0, 1, 32'h00500093, 32'h100, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("addi_valid", idu0_out_valid, 1'b1);
    checkOutput("addi_rd", idu0_out.rd_addr, 5'd1);
    checkOutput("addi_imm", idu0_out.imm, 32'h5);
    checkOutput("addi_imm_valid", idu0_out.imm_valid, 1'b1);
    checkOutput("addi_tag", idu0_out.instr_tag, 32'h100);
    applyStimulus(0, 0, '0, '0, 0, 0);

    // Back-pressure: six offered under stall, four accepted
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 32'h00000013, 32'h200 + i, 1, 0);
    checkOutput("bp_full", iq_full, 1'b1);
    checkOutput("bp_ready", instr_ready, 1'b0);
    checkOutput("bp_count", iq_count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, '0, '0, 0, 0);
      checkOutput("bp_drain_tag", idu0_out.instr_tag, 32'h200 + i);
      checkOutput("bp_drain_valid", idu0_out_valid, 1'b1);
    end
    checkOutput("bp_empty", iq_empty, 1'b1);
    applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("bp_valid_low", idu0_out_valid, 1'b0);

    // Steady state at 3 entries with push and pop together
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h00000013, 32'h300 + i, 1, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 32'h00000013, 32'h303 + i, 0, 0);
      checkOutput("steady_count", iq_count, 3'd3);
      checkOutput("steady_tag", idu0_out.instr_tag, 32'h300 + i);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, '0, 0, 0);

    // Flush with two queued, output live, and a push offered
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h00000013, 32'h400 + i, 1, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("pre_flush_count", iq_count, 3'd2);
    applyStimulus(0, 1, 32'h00000013, 32'hDEAD, 0, 1);
    checkOutput("flush_count", iq_count, 3'd0);
    checkOutput("flush_valid", idu0_out_valid, 1'b0);
    checkOutput("flush_payload", idu0_out, 128'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("flush_no_ghost", idu0_out_valid, 1'b0);

    // beq -4 and jal x1,+8 immediates
    applyStimulus(0, 1, 32'hFE000EE3, 32'h500, 0, 0);
    applyStimulus(0, 1, 32'h008000EF, 32'h504, 0, 0);
    checkOutput("beq_imm", idu0_out.imm, 32'hFFFFFFFC);
    checkOutput("beq_condbr", idu0_out.dec.condbr, 1'b1);
    applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("jal_imm20", idu0_out.dec.imm20, 1'b1);
    checkOutput("jal_imm_valid", idu0_out.imm_valid, 1'b0);
    checkOutput("jal_imm", idu0_out.imm, 32'h8);
    applyStimulus(0, 0, '0, '0, 0, 0);

`ifdef IDU0_IQ_PERF_EN
    base = perf_illegal;
    applyStimulus(0, 1, 32'h00000000, 32'h600, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    checkOutput("perf_illegal_delta", perf_illegal - base, 1);
    base = perf_stall_cyc;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, '0, 1, 0);
    checkOutput("perf_stall_delta", perf_stall_cyc - base, 5);
    applyStimulus(0, 0, '0, '0, 0, 0);
`endif

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rand_instr(),
                    $urandom(), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
